// File: rtl/decode_pkg.sv
// decode_pkg: decoded-instruction record passed from decode to issue
package decode_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] instr;
    logic        is_branch;
  } decode_data_t;
endpackage

// File: rtl/decode_issue_buffer.sv
// decode_issue_buffer: dual-ported in-order FIFO between decode and issue/rename
module decode_issue_buffer
  import decode_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [1:0]                in_valid,
  input  decode_data_t [1:0]        in_data,
  output logic                      in_ready,
  output logic [1:0]                out_valid,
  output decode_data_t [1:0]        out_data,
  input  logic [1:0]                out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  decode_data_t mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0] push_n, pop_n;
  logic pop0, pop1;
  assign out_valid = {count_q >= CW'(2), count_q != '0};
  assign out_data[0] = mem_q[head_q];
  assign out_data[1] = mem_q[head_q + AW'(1)];
  assign count = count_q;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  // push/pop amounts and next pointers; the illegal 2'b10 pattern pushes nothing
  always_comb begin
    in_ready = count_q <= CW'(DEPTH - 2);
    push_n = !in_ready ? 2'd0 : in_valid == 2'b11 ? 2'd2 : in_valid == 2'b01 ? 2'd1 : 2'd0;
    pop0 = out_valid[0] & out_ready[0];
    pop1 = pop0 & out_valid[1] & out_ready[1];
    pop_n = {1'b0, pop0} + {1'b0, pop1};
    head_d = flush ? '0 : head_q + AW'(pop_n);
    tail_d = flush ? '0 : tail_q + AW'(push_n);
    count_d = flush ? '0 : count_q + CW'(push_n) - CW'(pop_n);
  end
  // pointer and occupancy state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // entry storage, written at tail and tail+1; flushed pushes are dropped
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) mem_q[tail_q] <= in_data[0];
    if (!flush && push_n == 2'd2) mem_q[tail_q + AW'(1)] <= in_data[1];
  end
  a_legal_in: assert property (@(posedge clk) disable iff (!resetn) in_valid != 2'b10);
  a_no_over: assert property (@(posedge clk) disable iff (!resetn) count_q <= CW'(DEPTH));
  a_no_under: assert property (@(posedge clk) disable iff (!resetn) CW'(pop_n) <= count_q);
endmodule
